yarp_regfile_sb: RTL and testbench



---
 rtl/yarp_regfile_sb_if.sv | 31 +++
 rtl/yarp_regfile_sb.sv | 116 +++++++++++
 tb/tb_yarp_regfile_sb.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/yarp_regfile_sb_if.sv
// Decode/writeback bus of the YARP scoreboarded register file.
// The core side (decode + writeback) uses master; the register file uses slave.
interface yarp_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1_addr_i;
    logic [AW-1:0]   rs2_addr_i;
    logic [XLEN-1:0] rs1_data_o;
    logic [XLEN-1:0] rs2_data_o;
    logic            rs1_pend_o;
    logic            rs2_pend_o;
    logic [AW-1:0]   rd_addr_i;
    logic            wr_en_i;
    logic [XLEN-1:0] wr_data_i;
    logic            pend_set_i;
    logic [AW-1:0]   pend_addr_i;
    logic            ready_o;

    modport master (
        output rs1_addr_i, rs2_addr_i, rd_addr_i, wr_en_i, wr_data_i,
               pend_set_i, pend_addr_i,
        input  rs1_data_o, rs2_data_o, rs1_pend_o, rs2_pend_o, ready_o
    );

    modport slave (
        input  rs1_addr_i, rs2_addr_i, rd_addr_i, wr_en_i, wr_data_i,
               pend_set_i, pend_addr_i,
        output rs1_data_o, rs2_data_o, rs1_pend_o, rs2_pend_o, ready_o
    );
endinterface

// File: rtl/yarp_regfile_sb.sv
// YARP integer register file with post-reset clear sequencer and RAW pending-write scoreboard.
// Define YARP_RF_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module yarp_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    yarp_regfile_sb_if.slave rf
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    state_t          state_reg, state_next;
    logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;
    logic [XLEN-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0] pend_reg;
    wire  [NUM_REGS-1:0] pend_next;
    logic            run;
    logic            wr_fire;

    assign run     = (state_reg == ST_RUN);
    assign wr_fire = run && rf.wr_en_i && (rf.rd_addr_i != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= ST_INIT;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                clr_cnt_next = clr_cnt_reg + AW'(1);
                if (clr_cnt_reg == LAST_IDX) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // One entry is zeroed per INIT cycle; writeback is only honoured in RUN.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (!run) begin
                mem[clr_cnt_reg] <= '0;
            end else if (wr_fire) begin
                mem[rf.rd_addr_i] <= rf.wr_data_i;
            end
        end
    end

    // Scoreboard: a newly issued producer (set) wins over a retiring one (clr).
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
        if (gi == 0) begin : g_zero
            assign pend_next[gi] = 1'b0;
        end else begin : g_bit
            wire set_w = run && rf.pend_set_i && (rf.pend_addr_i == AW'(gi));
            wire clr_w = run && rf.wr_en_i    && (rf.rd_addr_i   == AW'(gi));
            assign pend_next[gi] = set_w | (pend_reg[gi] & ~clr_w);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_c;
        logic            pend_c;

        assign addr = (gi == 0) ? rf.rs1_addr_i : rf.rs2_addr_i;

        always_comb begin
            data_c = '0;
            pend_c = 1'b0;
            if (run && (addr != '0)) begin
                data_c = mem[addr];
                pend_c = pend_reg[addr];
`ifdef YARP_RF_BYPASS_EN
                // The retiring write satisfies the read unless a newer producer issues now.
                if (rf.wr_en_i && (rf.rd_addr_i == addr)) begin
                    data_c = rf.wr_data_i;
                    pend_c = rf.pend_set_i && (rf.pend_addr_i == addr);
                end
`endif
            end
        end
    end

    assign rf.rs1_data_o = g_rd[0].data_c;
    assign rf.rs2_data_o = g_rd[1].data_c;
    assign rf.rs1_pend_o = g_rd[0].pend_c;
    assign rf.rs2_pend_o = g_rd[1].pend_c;
    assign rf.ready_o    = run;

endmodule

// File: tb/tb_yarp_regfile_sb.sv
// Bench for yarp_regfile_sb: 32x32 instance checked every cycle against a reference model,
// plus a 16x64 instance for the parameter sweep. Honors YARP_RF_BYPASS_EN when defined.
module tb_yarp_regfile_sb;

    localparam int NR  = 32;
    localparam int NR2 = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    yarp_regfile_sb_if #(.XLEN(32), .AW(5)) bus  ();
    yarp_regfile_sb_if #(.XLEN(64), .AW(4)) bus2 ();

    yarp_regfile_sb #(.XLEN(32), .NUM_REGS(NR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rf      (bus)
    );

    yarp_regfile_sb #(.XLEN(64), .NUM_REGS(NR2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .rf      (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents, pending flags and readiness by cycle count.
    logic [31:0] m_mem  [NR];
    bit          m_pend [NR];
    bit          m_ready = 1'b0;
    int          m_cnt   = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            for (int i = 0; i < NR; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == NR) m_ready = 1'b1;
        end else begin
            if (bus.wr_en_i) begin
                if (bus.rd_addr_i != 0) m_mem[bus.rd_addr_i] = bus.wr_data_i;
                m_pend[bus.rd_addr_i] = 1'b0;
            end
            if (bus.pend_set_i && bus.pend_addr_i != 0) m_pend[bus.pend_addr_i] = 1'b1;
        end
    end

    function automatic void model_read(input logic [4:0] a, output logic [31:0] d, output bit p);
        d = '0;
        p = 1'b0;
        if (m_ready && a != 0) begin
            d = m_mem[a];
            p = m_pend[a];
`ifdef YARP_RF_BYPASS_EN
            if (bus.wr_en_i && bus.rd_addr_i == a) begin
                d = bus.wr_data_i;
                p = bus.pend_set_i && (bus.pend_addr_i == a);
            end
`endif
        end
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            logic [31:0] d1, d2;
            bit p1, p2;
            model_read(bus.rs1_addr_i, d1, p1);
            model_read(bus.rs2_addr_i, d2, p2);
            check("model_ready",    bus.ready_o,    m_ready);
            check("model_rs1_data", bus.rs1_data_o, d1);
            check("model_rs2_data", bus.rs2_data_o, d2);
            check("model_rs1_pend", bus.rs1_pend_o, p1);
            check("model_rs2_pend", bus.rs2_pend_o, p2);
        end
    end

    // One cycle: apply inputs just after the edge, return at the following negedge.
    task automatic drive(input bit wr, input logic [4:0] rd, input logic [31:0] data,
                         input bit ps, input logic [4:0] pa,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        bus.wr_en_i     = wr;
        bus.rd_addr_i   = rd;
        bus.wr_data_i   = data;
        bus.pend_set_i  = ps;
        bus.pend_addr_i = pa;
        bus.rs1_addr_i  = r1;
        bus.rs2_addr_i  = r2;
        @(negedge clk);
    endtask

    // Counts sampled cycles with ready_o low for each instance, bounded at 100.
    task automatic wait_ready(input int exp1, input int exp2, input int drop_wr);
        int c1 = 0;
        int c2 = 0;
        bit d1 = 1'b0;
        bit d2 = 1'b0;
        for (int k = 0; k < 100 && !(d1 && d2); k++) begin
            @(negedge clk);
            if (k == drop_wr) bus.wr_en_i = 1'b0;
            if (!d1) begin
                if (bus.ready_o) d1 = 1'b1; else c1++;
            end
            if (!d2) begin
                if (bus2.ready_o) d2 = 1'b1; else c2++;
            end
        end
        bus.wr_en_i = 1'b0;
        check("ready_latency_32x32", c1, exp1);
        check("ready_latency_16x64", c2, exp2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        bus.wr_en_i      = 1'b0;
        bus.rd_addr_i    = '0;
        bus.wr_data_i    = '0;
        bus.pend_set_i   = 1'b0;
        bus.pend_addr_i  = '0;
        bus.rs1_addr_i   = '0;
        bus.rs2_addr_i   = '0;
        bus2.wr_en_i     = 1'b0;
        bus2.rd_addr_i   = '0;
        bus2.wr_data_i   = '0;
        bus2.pend_set_i  = 1'b0;
        bus2.pend_addr_i = '0;
        bus2.rs1_addr_i  = '0;
        bus2.rs2_addr_i  = '0;

        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        @(negedge clk);
        check("reset_ready",  bus.ready_o,    1'b0);
        check("reset_ready2", bus2.ready_o,   1'b0);
        check("reset_rs1",    bus.rs1_data_o, 32'h0);

        // Release with a write to x5 in flight during INIT; it must be lost.
        @(posedge clk);
        #1;
        reset_n       = 1'b1;
        bus.wr_en_i   = 1'b1;
        bus.rd_addr_i = 5'd5;
        bus.wr_data_i = 32'hDEAD_BEEF;
        wait_ready(32, 16, 5);

        for (int i = 1; i < NR; i++) begin
            drive(0, 0, 0, 0, 0, i[4:0], i[4:0]);
            check("cleared_rs1", bus.rs1_data_o, 32'h0);
            check("cleared_rs2", bus.rs2_data_o, 32'h0);
        end

        drive(1, 7, 32'h1234_5678, 0, 0, 7, 0);
        drive(0, 0, 0, 0, 0, 7, 0);
        check("write_x7", bus.rs1_data_o, 32'h1234_5678);

        drive(1, 0, 32'hFFFF_FFFF, 0, 0, 7, 0);
        drive(0, 0, 0, 0, 0, 7, 0);
        check("write_x0_discarded", bus.rs2_data_o, 32'h0);
        check("x7_kept",            bus.rs1_data_o, 32'h1234_5678);

        drive(0, 0, 0, 1, 9, 9, 0);
        check("pend_set_no_bypass", bus.rs1_pend_o, 1'b0);
        drive(0, 0, 0, 0, 0, 9, 0);
        check("pend_set_x9", bus.rs1_pend_o, 1'b1);

        drive(1, 9, 32'hA5A5_A5A5, 0, 0, 9, 9);
`ifdef YARP_RF_BYPASS_EN
        check("bypass_x9_data", bus.rs1_data_o, 32'hA5A5_A5A5);
        check("bypass_x9_pend", bus.rs1_pend_o, 1'b0);
`else
        check("nobypass_x9_data", bus.rs1_data_o, 32'h0);
        check("nobypass_x9_pend", bus.rs1_pend_o, 1'b1);
`endif
        drive(0, 0, 0, 0, 0, 9, 9);
        check("pend_clr_x9", bus.rs1_pend_o, 1'b0);
        check("data_x9",     bus.rs1_data_o, 32'hA5A5_A5A5);

        drive(1, 9, 32'h0000_0011, 1, 9, 9, 0);
        drive(0, 0, 0, 0, 0, 9, 0);
        check("set_beats_clr", bus.rs1_pend_o, 1'b1);
        check("set_clr_data",  bus.rs1_data_o, 32'h0000_0011);
        drive(1, 9, 32'h0000_0022, 0, 0, 9, 0);
        drive(0, 0, 0, 0, 0, 9, 0);
        check("x9_retired", bus.rs1_pend_o, 1'b0);

        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("pend_x0_never", bus.rs2_pend_o, 1'b0);

        drive(1, 3, 32'hCAFE_0001, 0, 0, 3, 3);
`ifdef YARP_RF_BYPASS_EN
        check("bypass_x3_same", bus.rs1_data_o, 32'hCAFE_0001);
`else
        check("old_x3_same",    bus.rs1_data_o, 32'h0);
`endif
        drive(0, 0, 0, 0, 0, 3, 3);
        check("x3_next", bus.rs1_data_o, 32'hCAFE_0001);

        // Mixed traffic: overlapping writes, sets and reads; the model checks each cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1, 5'(10 + i), 32'h0101_0101 * (i + 1), 1, 5'(12 + i), 5'(9 + i), 5'(12 + i));
        end
        for (int i = 0; i < 8; i++) begin
            drive(i[0], 5'(12 + i), 32'hF0F0_0000 + i, 0, 0, 5'(10 + i), 5'(12 + i));
        end

        @(posedge clk);
        #1;
        bus2.wr_en_i    = 1'b1;
        bus2.rd_addr_i  = 4'd15;
        bus2.wr_data_i  = 64'h0123_4567_89AB_CDEF;
        bus2.rs1_addr_i = 4'd15;
        bus2.rs2_addr_i = 4'd0;
        @(posedge clk);
        #1;
        bus2.wr_en_i = 1'b0;
        @(negedge clk);
        check("sweep_x15_64b", bus2.rs1_data_o, 64'h0123_4567_89AB_CDEF);
        check("sweep_x0_64b",  bus2.rs2_data_o, 64'h0);

        drive(1, 4, 32'h0000_0055, 0, 0, 4, 0);
        drive(0, 0, 0, 1, 4, 4, 0);
        drive(0, 0, 0, 0, 0, 4, 0);
        check("x4_before_reset",   bus.rs1_data_o, 32'h0000_0055);
        check("x4_pend_before",    bus.rs1_pend_o, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_ready(32, 16, 200);
        drive(0, 0, 0, 0, 0, 4, 9);
        check("x4_after_reset",      bus.rs1_data_o, 32'h0);
        check("x4_pend_after_reset", bus.rs1_pend_o, 1'b0);
        check("x9_after_reset",      bus.rs2_data_o, 32'h0);
        check("sweep_x15_after_reset", bus2.rs1_data_o, 64'h0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
